stream_core: RTL

Parametrised execution core for the tape machine. It fetches 3-bit opcodes from synchronous program memory and executes them against a synchronous tape RAM. Cell and tape-address widths are configurable, matching brackets are found by a depth-counted scan, and byte I/O uses valid/ready handshakes for both output and input. It replaces the fixed-width, output-only core inside the `cpu` top; `ram` and `rom_pmem` attach unchanged.

---
 rtl/stream_core_if.sv | 23 ++
 rtl/stream_core.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_core_if.sv
// rtl/stream_core_if.sv - byte input/output handshake bundle for stream_core
interface stream_core_if #(
   parameter int CELL_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [CELL_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [CELL_WIDTH-1:0] out_data;

   // Core side: consumes the input stream, produces the output stream
   modport master (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   // Environment side
   modport slave (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/stream_core.sv
// rtl/stream_core.sv - tape machine execution core with bracket scan and stream I/O
module stream_core #(
   parameter int CELL_WIDTH  = 8,
   parameter int TAPE_AW     = 16,
   parameter int PC_WIDTH    = 16,
   parameter int PROG_LEN    = 1024,
   parameter int DEPTH_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   output logic [PC_WIDTH-1:0]   pmem_addr,
   input  logic [2:0]            pmem_data,
   output logic [TAPE_AW-1:0]    tape_addr,
   output logic                  tape_we,
   output logic [CELL_WIDTH-1:0] tape_wdata,
   input  logic [CELL_WIDTH-1:0] tape_rdata,
   stream_core_if.master         io,
   output logic                  halted,
   output logic                  error
);
   localparam logic [2:0] OP_INC   = 3'd0;
   localparam logic [2:0] OP_DEC   = 3'd1;
   localparam logic [2:0] OP_RIGHT = 3'd2;
   localparam logic [2:0] OP_LEFT  = 3'd3;
   localparam logic [2:0] OP_OPEN  = 3'd4;
   localparam logic [2:0] OP_CLOSE = 3'd5;
   localparam logic [2:0] OP_OUT   = 3'd6;
   localparam logic [2:0] OP_IN    = 3'd7;

   localparam logic [PC_WIDTH-1:0]    PC_END    = PC_WIDTH'(PROG_LEN);
   localparam logic [PC_WIDTH-1:0]    PC_ONE    = PC_WIDTH'(1);
   localparam logic [TAPE_AW-1:0]     SP_ONE    = TAPE_AW'(1);
   localparam logic [CELL_WIDTH-1:0]  CELL_ONE  = CELL_WIDTH'(1);
   localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE = DEPTH_WIDTH'(1);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_SCAN_F_FETCH, S_SCAN_F_CHECK,
      S_SCAN_B_FETCH, S_SCAN_B_CHECK, S_OUT, S_IN, S_HALT
   } state_t;

   state_t                 state;
   logic [PC_WIDTH-1:0]    pc;
   logic [PC_WIDTH-1:0]    pc_inc;
   logic [PC_WIDTH-1:0]    pc_dec;
   logic [TAPE_AW-1:0]     sp;
   logic [DEPTH_WIDTH-1:0] depth;
   logic [DEPTH_WIDTH-1:0] depth_next;
   logic                   depth_ovf;
   logic                   cell_zero;
   logic                   in_fire;

   assign pmem_addr = pc;
   assign tape_addr = sp;
   assign pc_inc    = pc + PC_ONE;
   assign pc_dec    = pc - PC_ONE;
   assign cell_zero = (tape_rdata == '0);
   assign in_fire   = (state == S_IN) && io.in_ready && io.in_valid;

   // Tape write strobe is decoded in the same cycle the cell arrives, so the write
   // lands at the end of DECODE/IN and the following FETCH reads the updated cell
   always_comb begin
      tape_we    = 1'b0;
      tape_wdata = '0;
      if (state == S_DECODE && pmem_data == OP_INC) begin
         tape_we    = 1'b1;
         tape_wdata = tape_rdata + CELL_ONE;
      end else if (state == S_DECODE && pmem_data == OP_DEC) begin
         tape_we    = 1'b1;
         tape_wdata = tape_rdata - CELL_ONE;
      end else if (in_fire) begin
         tape_we    = 1'b1;
         tape_wdata = io.in_data;
      end
   end

   // Bracket nesting update: forward scan nests on '[', backward scan nests on ']'
   always_comb begin
      depth_next = depth;
      depth_ovf  = 1'b0;
      if ((state == S_SCAN_F_CHECK && pmem_data == OP_OPEN) ||
          (state == S_SCAN_B_CHECK && pmem_data == OP_CLOSE)) begin
         depth_ovf  = (depth == '1);
         depth_next = depth + DEPTH_ONE;
      end else if ((state == S_SCAN_F_CHECK && pmem_data == OP_CLOSE) ||
                   (state == S_SCAN_B_CHECK && pmem_data == OP_OPEN)) begin
         depth_next = depth - DEPTH_ONE;
      end
   end

   // Sequencer: fetch/decode/scan/IO states with registered handshake and status outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_FETCH;
         pc           <= '0;
         sp           <= '0;
         depth        <= '0;
         io.out_valid <= 1'b0;
         io.out_data  <= '0;
         io.in_ready  <= 1'b0;
         halted       <= 1'b0;
         error        <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (pc == PC_END) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end else begin
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (pmem_data)
                  OP_INC, OP_DEC: begin
                     pc    <= pc_inc;
                     state <= S_FETCH;
                  end
                  OP_RIGHT: begin
                     sp    <= sp + SP_ONE;
                     pc    <= pc_inc;
                     state <= S_FETCH;
                  end
                  OP_LEFT: begin
                     sp    <= sp - SP_ONE;
                     pc    <= pc_inc;
                     state <= S_FETCH;
                  end
                  OP_OPEN: begin
                     pc <= pc_inc;
                     if (cell_zero) begin
                        depth <= DEPTH_ONE;
                        state <= S_SCAN_F_FETCH;
                     end else begin
                        state <= S_FETCH;
                     end
                  end
                  OP_CLOSE: begin
                     if (cell_zero) begin
                        pc    <= pc_inc;
                        state <= S_FETCH;
                     end else if (pc == '0) begin
                        // A ']' at address 0 has nothing behind it to match
                        state  <= S_HALT;
                        halted <= 1'b1;
                        error  <= 1'b1;
                     end else begin
                        depth <= DEPTH_ONE;
                        pc    <= pc_dec;
                        state <= S_SCAN_B_FETCH;
                     end
                  end
                  OP_OUT: begin
                     io.out_data  <= tape_rdata;
                     io.out_valid <= 1'b1;
                     state        <= S_OUT;
                  end
                  OP_IN: begin
                     io.in_ready <= 1'b1;
                     state       <= S_IN;
                  end
               endcase
            end
            S_SCAN_F_FETCH: begin
               // Reached only past the end when '[' was the last instruction
               if (pc == PC_END) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
                  error  <= 1'b1;
               end else begin
                  state <= S_SCAN_F_CHECK;
               end
            end
            S_SCAN_F_CHECK: begin
               if (depth_ovf) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
                  error  <= 1'b1;
               end else if (depth_next == '0) begin
                  depth <= '0;
                  pc    <= pc_inc;
                  state <= S_FETCH;
               end else if (pc_inc == PC_END) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
                  error  <= 1'b1;
               end else begin
                  depth <= depth_next;
                  pc    <= pc_inc;
                  state <= S_SCAN_F_FETCH;
               end
            end
            S_SCAN_B_FETCH: begin
               state <= S_SCAN_B_CHECK;
            end
            S_SCAN_B_CHECK: begin
               if (depth_ovf) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
                  error  <= 1'b1;
               end else if (depth_next == '0) begin
                  // Resume just after the matching '[' without re-testing it
                  depth <= '0;
                  pc    <= pc_inc;
                  state <= S_FETCH;
               end else if (pc == '0) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
                  error  <= 1'b1;
               end else begin
                  depth <= depth_next;
                  pc    <= pc_dec;
                  state <= S_SCAN_B_FETCH;
               end
            end
            S_OUT: begin
               if (io.out_ready) begin
                  io.out_valid <= 1'b0;
                  pc           <= pc_inc;
                  state        <= S_FETCH;
               end
            end
            S_IN: begin
               if (io.in_valid) begin
                  io.in_ready <= 1'b0;
                  pc          <= pc_inc;
                  state       <= S_FETCH;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end
endmodule
